// File: rtl/pc_unit_if.sv
// Execute/step control bus between the core sequencer and the program-counter unit.
// The slave side is the PC unit; the master side is the core's decode/regfile stage.
interface pc_unit_if #(
    parameter int XLEN = 32
);
    logic            en;
    logic            phase_execute;
    logic            phase_step;
    logic [31:0]     i_instr;
    logic [XLEN-1:0] r_ra;
    logic [XLEN-1:0] r_rb;
    logic            trap_req;
    logic [XLEN-1:0] trap_vector;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] r_data;
    logic            r_wen;
    logic            exc_misalign;
    logic [XLEN-1:0] exc_tval;
    logic            busy;

    modport master (
        output en, phase_execute, phase_step, i_instr, r_ra, r_rb, trap_req, trap_vector,
        input  pc, r_data, r_wen, exc_misalign, exc_tval, busy
    );

    modport slave (
        input  en, phase_execute, phase_step, i_instr, r_ra, r_rb, trap_req, trap_vector,
        output pc, r_data, r_wen, exc_misalign, exc_tval, busy
    );
endinterface

// File: rtl/pc_unit.sv
// Program counter with RV32I/RV64I BRANCH/JAL/JALR resolution, alignment checking
// and a trap redirect path, sequenced by the core's execute/step strobes.
module pc_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              IALIGN       = 32
) (
    input  logic     clk,
    input  logic     rst,
    pc_unit_if.slave bus
);
    typedef enum logic [1:0] {
        ST_READY   = 2'd0,
        ST_PENDING = 2'd1,
        ST_FAULT   = 2'd2
    } state_t;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // Low address bits that must be zero for a legal instruction target.
    localparam logic [XLEN-1:0] ALIGN_MASK = (IALIGN == 16) ? XLEN'(1) : XLEN'(3);

    state_t          state_reg, state_next;
    logic [XLEN-1:0] pc_reg, pc_next;
    logic [XLEN-1:0] next_pc_reg, next_pc_next;
    logic [XLEN-1:0] r_data_reg, r_data_next;
    logic            r_wen_reg, r_wen_next;
    logic            exc_reg, exc_next;
    logic [XLEN-1:0] tval_reg, tval_next;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [XLEN-1:0] imm_b, imm_j, imm_i;
    logic            is_branch, is_jal, is_jalr, is_link;
    logic            cond, taken, misaligned;
    logic [XLEN-1:0] pc_plus4, target, trap_target;

    assign opcode = bus.i_instr[6:0];
    assign funct3 = bus.i_instr[14:12];

    assign imm_b = {{(XLEN-13){bus.i_instr[31]}}, bus.i_instr[31], bus.i_instr[7],
                    bus.i_instr[30:25], bus.i_instr[11:8], 1'b0};
    assign imm_j = {{(XLEN-21){bus.i_instr[31]}}, bus.i_instr[31], bus.i_instr[19:12],
                    bus.i_instr[20], bus.i_instr[30:21], 1'b0};
    assign imm_i = {{(XLEN-12){bus.i_instr[31]}}, bus.i_instr[31:20]};

    assign is_branch = (opcode == OP_BRANCH);
    assign is_jal    = (opcode == OP_JAL);
    assign is_jalr   = (opcode == OP_JALR) && (funct3 == 3'b000);
    assign is_link   = is_jal || is_jalr;

    always_comb begin
        cond = 1'b0;
        unique case (funct3)
            3'b000:  cond = (bus.r_ra == bus.r_rb);
            3'b001:  cond = (bus.r_ra != bus.r_rb);
            3'b100:  cond = ($signed(bus.r_ra) <  $signed(bus.r_rb));
            3'b101:  cond = ($signed(bus.r_ra) >= $signed(bus.r_rb));
            3'b110:  cond = (bus.r_ra <  bus.r_rb);
            3'b111:  cond = (bus.r_ra >= bus.r_rb);
            default: cond = 1'b0;
        endcase
    end

    assign taken    = (is_branch && cond) || is_link;
    assign pc_plus4 = pc_reg + XLEN'(4);

    always_comb begin
        target = pc_plus4;
        if (is_jal)
            target = pc_reg + imm_j;
        else if (is_jalr)
            target = (bus.r_ra + imm_i) & ~XLEN'(1);
        else if (is_branch && cond)
            target = pc_reg + imm_b;
    end

    assign misaligned  = |(target & ALIGN_MASK);
    assign trap_target = bus.trap_vector & ~ALIGN_MASK;

    // Pulse outputs default low every cycle; all other state holds unless updated.
    always_comb begin
        state_next   = state_reg;
        pc_next      = pc_reg;
        next_pc_next = next_pc_reg;
        r_data_next  = r_data_reg;
        tval_next    = tval_reg;
        r_wen_next   = 1'b0;
        exc_next     = 1'b0;
        if (!bus.en) begin
            state_next = state_reg;
        end else if (bus.trap_req) begin
            pc_next    = trap_target;
            state_next = ST_READY;
        end else begin
            unique case (state_reg)
                ST_READY: begin
                    if (bus.phase_execute) begin
                        if (taken && misaligned) begin
                            exc_next   = 1'b1;
                            tval_next  = target;
                            state_next = ST_FAULT;
                        end else begin
                            next_pc_next = target;
                            state_next   = ST_PENDING;
                            if (is_link) begin
                                r_data_next = pc_plus4;
                                r_wen_next  = 1'b1;
                            end
                        end
                    end
                end
                ST_PENDING: begin
                    if (bus.phase_step) begin
                        pc_next    = next_pc_reg;
                        state_next = ST_READY;
                    end
                end
                ST_FAULT: state_next = ST_FAULT;
                default:  state_next = ST_READY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_READY;
            pc_reg      <= RESET_VECTOR;
            next_pc_reg <= RESET_VECTOR;
            r_data_reg  <= '0;
            r_wen_reg   <= 1'b0;
            exc_reg     <= 1'b0;
            tval_reg    <= '0;
        end else begin
            state_reg   <= state_next;
            pc_reg      <= pc_next;
            next_pc_reg <= next_pc_next;
            r_data_reg  <= r_data_next;
            r_wen_reg   <= r_wen_next;
            exc_reg     <= exc_next;
            tval_reg    <= tval_next;
        end
    end

    assign bus.pc           = pc_reg;
    assign bus.r_data       = r_data_reg;
    assign bus.r_wen        = r_wen_reg;
    assign bus.exc_misalign = exc_reg;
    assign bus.exc_tval     = tval_reg;
    assign bus.busy         = (state_reg != ST_READY);
endmodule

// File: tb/tb_pc_unit.sv
// Directed checks of pc_unit in three configurations: 32-bit/IALIGN32, 64-bit wrap,
// and 32-bit/IALIGN16.
module tb_pc_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    localparam logic [31:0] ADDI   = 32'h0000_0013;
    localparam logic [31:0] BEQ16  = 32'h0020_8863;
    localparam logic [31:0] BLT16  = 32'h0020_C863;
    localparam logic [31:0] BLTU16 = 32'h0020_E863;
    localparam logic [31:0] JALM8  = 32'hFF9F_F0EF;
    localparam logic [31:0] JALP2  = 32'h0020_00EF;
    localparam logic [31:0] JALR0  = 32'h0000_80E7;

    always #5 clk = ~clk;

    pc_unit_if #(.XLEN(32)) bus_a ();
    pc_unit_if #(.XLEN(64)) bus_b ();
    pc_unit_if #(.XLEN(32)) bus_c ();

    pc_unit #(.XLEN(32), .RESET_VECTOR(32'h100), .IALIGN(32)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a));
    pc_unit #(.XLEN(64), .RESET_VECTOR(64'hFFFF_FFFF_FFFF_FFFC), .IALIGN(32)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b));
    pc_unit #(.XLEN(32), .RESET_VECTOR(32'h100), .IALIGN(16)) dut_c (
        .clk(clk), .rst(rst), .bus(bus_c));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic exec_a(input logic [31:0] ins, input logic [31:0] ra, input logic [31:0] rb);
        bus_a.i_instr = ins;
        bus_a.r_ra = ra;
        bus_a.r_rb = rb;
        bus_a.phase_execute = 1'b1;
        tick();
        bus_a.phase_execute = 1'b0;
    endtask

    task automatic step_a();
        bus_a.phase_step = 1'b1;
        tick();
        bus_a.phase_step = 1'b0;
    endtask

    task automatic trap_a(input logic [31:0] vec);
        bus_a.trap_req = 1'b1;
        bus_a.trap_vector = vec;
        tick();
        bus_a.trap_req = 1'b0;
    endtask

    initial begin
        bus_a.en = 1'b1; bus_a.phase_execute = 1'b0; bus_a.phase_step = 1'b0;
        bus_a.i_instr = ADDI; bus_a.r_ra = '0; bus_a.r_rb = '0;
        bus_a.trap_req = 1'b0; bus_a.trap_vector = '0;
        bus_b.en = 1'b1; bus_b.phase_execute = 1'b0; bus_b.phase_step = 1'b0;
        bus_b.i_instr = ADDI; bus_b.r_ra = '0; bus_b.r_rb = '0;
        bus_b.trap_req = 1'b0; bus_b.trap_vector = '0;
        bus_c.en = 1'b1; bus_c.phase_execute = 1'b0; bus_c.phase_step = 1'b0;
        bus_c.i_instr = ADDI; bus_c.r_ra = '0; bus_c.r_rb = '0;
        bus_c.trap_req = 1'b0; bus_c.trap_vector = '0;

        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("reset_pc", bus_a.pc, 64'h100);
        chk("reset_busy", bus_a.busy, 0);
        chk("reset_rwen", bus_a.r_wen, 0);
        chk("reset_rdata", bus_a.r_data, 0);
        chk("reset_exc", bus_a.exc_misalign, 0);
        chk("reset_tval", bus_a.exc_tval, 0);
        chk("reset_pc64", bus_b.pc, 64'hFFFF_FFFF_FFFF_FFFC);

        // ADDI: execute then step advances by 4 without a link write
        exec_a(ADDI, 0, 0);
        chk("addi_exec_pc", bus_a.pc, 64'h100);
        chk("addi_exec_busy", bus_a.busy, 1);
        chk("addi_exec_rwen", bus_a.r_wen, 0);
        step_a();
        chk("addi_step_pc", bus_a.pc, 64'h104);
        chk("addi_step_busy", bus_a.busy, 0);
        chk("addi_step_rwen", bus_a.r_wen, 0);

        trap_a(32'h100);
        chk("trap_set_pc", bus_a.pc, 64'h100);
        exec_a(BEQ16, 5, 5);
        step_a();
        chk("beq_taken_pc", bus_a.pc, 64'h110);

        trap_a(32'h100);
        exec_a(BEQ16, 5, 6);
        step_a();
        chk("beq_not_taken_pc", bus_a.pc, 64'h104);

        trap_a(32'h100);
        exec_a(BLTU16, 32'hFFFF_FFFF, 1);
        step_a();
        chk("bltu_not_taken_pc", bus_a.pc, 64'h104);

        trap_a(32'h100);
        exec_a(BLT16, 32'hFFFF_FFFF, 1);
        step_a();
        chk("blt_taken_pc", bus_a.pc, 64'h110);

        // JAL -8 from 0x200 links 0x204
        trap_a(32'h200);
        exec_a(JALM8, 0, 0);
        chk("jal_rwen", bus_a.r_wen, 1);
        chk("jal_rdata", bus_a.r_data, 64'h204);
        chk("jal_exc", bus_a.exc_misalign, 0);
        step_a();
        chk("jal_rwen_pulse", bus_a.r_wen, 0);
        chk("jal_pc", bus_a.pc, 64'h1F8);

        exec_a(JALR0, 32'h301, 0);
        chk("jalr_rwen", bus_a.r_wen, 1);
        chk("jalr_rdata", bus_a.r_data, 64'h1FC);
        step_a();
        chk("jalr_pc", bus_a.pc, 64'h300);

        // Misaligned JALR target faults and blocks stepping until a trap
        exec_a(JALR0, 32'h302, 0);
        chk("mis_exc", bus_a.exc_misalign, 1);
        chk("mis_tval", bus_a.exc_tval, 64'h302);
        chk("mis_busy", bus_a.busy, 1);
        chk("mis_rwen", bus_a.r_wen, 0);
        chk("mis_pc", bus_a.pc, 64'h300);
        step_a();
        chk("mis_exc_pulse", bus_a.exc_misalign, 0);
        chk("mis_step_pc", bus_a.pc, 64'h300);
        chk("mis_step_busy", bus_a.busy, 1);
        exec_a(ADDI, 0, 0);
        chk("mis_exec_ignored", bus_a.pc, 64'h300);
        trap_a(32'h803);
        chk("mis_trap_pc", bus_a.pc, 64'h800);
        chk("mis_trap_busy", bus_a.busy, 0);
        chk("mis_tval_hold", bus_a.exc_tval, 64'h302);

        // Trap while PENDING drops the latched target
        exec_a(ADDI, 0, 0);
        chk("pend_busy", bus_a.busy, 1);
        trap_a(32'h400);
        chk("pend_trap_pc", bus_a.pc, 64'h400);
        chk("pend_trap_busy", bus_a.busy, 0);
        step_a();
        chk("pend_drop_pc", bus_a.pc, 64'h400);

        // en=0 freezes everything even with both strobes high
        exec_a(ADDI, 0, 0);
        bus_a.en = 1'b0;
        bus_a.i_instr = JALM8;
        bus_a.phase_execute = 1'b1;
        bus_a.phase_step = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("en0_pc", bus_a.pc, 64'h400);
            chk("en0_busy", bus_a.busy, 1);
            chk("en0_rwen", bus_a.r_wen, 0);
        end
        bus_a.en = 1'b1;
        bus_a.phase_execute = 1'b0;
        bus_a.phase_step = 1'b0;
        step_a();
        chk("en1_step_pc", bus_a.pc, 64'h404);

        // Both strobes in READY: execute wins, step ignored
        bus_a.i_instr = ADDI;
        bus_a.phase_execute = 1'b1;
        bus_a.phase_step = 1'b1;
        tick();
        bus_a.phase_execute = 1'b0;
        bus_a.phase_step = 1'b0;
        chk("both_pc", bus_a.pc, 64'h404);
        chk("both_busy", bus_a.busy, 1);
        step_a();
        chk("both_step_pc", bus_a.pc, 64'h408);

        // 64-bit wrap and sign-extended JAL
        bus_b.i_instr = ADDI;
        bus_b.phase_execute = 1'b1;
        tick();
        bus_b.phase_execute = 1'b0;
        bus_b.phase_step = 1'b1;
        tick();
        bus_b.phase_step = 1'b0;
        chk("wrap64_pc", bus_b.pc, 64'h0);
        bus_b.i_instr = JALM8;
        bus_b.phase_execute = 1'b1;
        tick();
        bus_b.phase_execute = 1'b0;
        chk("jal64_rdata", bus_b.r_data, 64'h4);
        chk("jal64_rwen", bus_b.r_wen, 1);
        bus_b.phase_step = 1'b1;
        tick();
        bus_b.phase_step = 1'b0;
        chk("jal64_pc", bus_b.pc, 64'hFFFF_FFFF_FFFF_FFF8);

        // IALIGN=16: halfword targets are legal
        bus_c.i_instr = JALP2;
        bus_c.phase_execute = 1'b1;
        tick();
        bus_c.phase_execute = 1'b0;
        chk("ia16_exc", bus_c.exc_misalign, 0);
        chk("ia16_rwen", bus_c.r_wen, 1);
        chk("ia16_rdata", bus_c.r_data, 64'h104);
        bus_c.phase_step = 1'b1;
        tick();
        bus_c.phase_step = 1'b0;
        chk("ia16_pc", bus_c.pc, 64'h102);
        bus_c.trap_req = 1'b1;
        bus_c.trap_vector = 32'h803;
        tick();
        bus_c.trap_req = 1'b0;
        chk("ia16_trap_pc", bus_c.pc, 64'h802);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
Parametrised successor to the core's program counter. Owns the PC and resolves RV32I/RV64I control flow (BRANCH, JAL, JALR) from the raw instruction word, with decoding done internally. Adds a configurable reset vector, an instruction-alignment check with a misaligned-target exception, and a trap redirect path. It sits between the decode/regfile stage and fetch, and is sequenced by the core's phase_execute/phase_step strobes.

Parameters:
XLEN, 32, datapath/PC width (32 or 64)
RESET_VECTOR, 0, PC value loaded on reset (XLEN bits; must be IALIGN-aligned)
IALIGN, 32, instruction alignment in bits (16: target[0] must be 0; 32: target[1:0] must be 0)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
en  in  1  global enable; low freezes all state
phase_execute  in  1  execute strobe, one cycle
phase_step  in  1  step strobe, one cycle
i_instr  in  32  current instruction word
r_ra  in  XLEN  rs1 value
r_rb  in  XLEN  rs2 value
trap_req  in  1  trap redirect request
trap_vector  in  XLEN  trap target
pc  out  XLEN  current PC
r_data  out  XLEN  link value for rd
r_wen  out  1  rd write strobe
exc_misalign  out  1  misaligned-target exception pulse
exc_tval  out  XLEN  faulting target address
busy  out  1  high when state != READY

Behaviour:
- Reset: one clock, synchronous, active-high. Reset is fully synchronous and active-high; clock and reset ports are clk and rst. When rst=1 at a rising edge: pc=RESET_VECTOR, r_data=0, r_wen=0, exc_misalign=0, exc_tval=0, state=READY. rst overrides en, trap_req and in-flight operations.
- States:
  - READY: waiting for execute.
  - PENDING: next_pc latched, waiting for step.
  - FAULT: misaligned target, waiting for trap.
- Priority per cycle: rst > !en > trap_req > phase_execute > phase_step.
- en=0: all registers hold. r_wen and exc_misalign are driven 0 that cycle.
- trap_req=1, any state: pc <= trap_vector with low alignment bits cleared (bit0 for IALIGN=16, bits[1:0] for IALIGN=32); state <= READY; r_wen=0. A pending next_pc is discarded.
- Immediate decode (all sign-extended to XLEN):
  - B-type: {i[31],i[7],i[30:25],i[11:8],0}
  - J-type: {i[31],i[19:12],i[20],i[30:21],0}
  - I-type: i[31:20]
- Opcodes:
  - BRANCH (1100011): func3 000 eq, 001 ne, 100 signed lt, 101 signed ge, 110 unsigned lt, 111 unsigned ge. If the condition holds, target = pc + immB; otherwise pc + 4. func3 010/011 are treated as not taken.
  - JAL (1101111): target = pc + immJ; link.
  - JALR (1100111, func3 000): target = (r_ra + immI) & ~1; link. JALR with any other func3 is treated as an unrecognised opcode.
  - Any other opcode: target = pc + 4, no link.
- All arithmetic is modulo 2^XLEN; wrap-around is silent.
- phase_execute in READY: compute target.
  - Misaligned and the path is taken/jump: exc_misalign=1 for exactly one cycle, exc_tval=target, state <= FAULT, r_wen=0, pc unchanged.
  - Otherwise: next_pc <= target, state <= PENDING. For JAL/JALR, r_data <= pc + 4 and r_wen=1 for exactly one cycle.
  - A not-taken branch never faults, since pc + 4 is always aligned.
- phase_step in PENDING: pc <= next_pc, state <= READY. The following cycle's execute is honoured.
- Ignored strobes: phase_step in READY or FAULT; phase_execute in PENDING or FAULT. Both strobes high in READY: execute wins and the step is ignored.
- r_wen and exc_misalign are never high in the same cycle.
- busy = (state != READY), registered.

Test Plan:
- Reset/step: RESET_VECTOR=0x100; rst, then execute+step on ADDI (0x00000013) -> pc 0x100 then 0x104; r_wen stays 0.
- BEQ taken/not-taken: pc=0x100, BEQ imm +16, ra=rb=5 -> pc=0x110. Repeat with rb=6 -> pc=0x104. BLTU with ra=0xFFFFFFFF, rb=1 -> not taken. BLT on the same operands -> taken.
- JAL/JALR link: pc=0x200, JAL imm -8 -> r_wen pulse, r_data=0x204, pc=0x1F8 after step. JALR ra=0x301, imm 0 -> pc=0x300.
- Misalign: IALIGN=32, JALR ra=0x302 -> exc_misalign pulse, exc_tval=0x302, busy=1, step ignored, pc held. trap_req with trap_vector=0x803 -> pc=0x800, busy=0.
- Trap mid-op and enable: trap_req in PENDING -> pending target dropped, pc=trap_vector. en=0 with both strobes high for 3 cycles -> no state change. Both strobes high in READY -> only execute is taken.
- Wrap/width: XLEN=64, pc=0xFFFF_FFFF_FFFF_FFFC, ADDI then step -> pc=0. IALIGN=16, JAL imm +2 -> no exception.
